// File: rtl/mbldcm_commutation_sequencer.sv
// Commutation phase sequencer for the BLDC motor core: steps a 3-bit phase index
// every programmable number of cycles, with pause, preload and double-buffered period.
module mbldcm_commutation_sequencer #(
    parameter int unsigned                PERIOD_WIDTH       = 16,
    parameter logic [2:0]                 TOTAL_PHASE_STAGES = 3'd6,
    parameter logic [PERIOD_WIDTH-1:0]    MIN_PERIOD         = PERIOD_WIDTH'(2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    hold,
    input  logic                    dir,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    period_we,
    input  logic [2:0]              phase_init,
    input  logic                    phase_load,
    output logic [2:0]              phase,
    output logic                    step,
    output logic                    rev_tick,
    output logic                    active,
    output logic                    period_pending
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_PHASE = TOTAL_PHASE_STAGES - 3'd1;

    state_t                  state, state_nxt;
    logic [PERIOD_WIDTH-1:0] cnt, cnt_nxt;
    logic [PERIOD_WIDTH-1:0] active_period, active_period_nxt;
    logic [PERIOD_WIDTH-1:0] pending_period, pending_period_nxt;
    logic                    pending_nxt;
    logic [2:0]              phase_nxt;
    logic                    step_nxt;
    logic                    rev_tick_nxt;
    logic                    at_end;
    logic                    step_now;
    logic [PERIOD_WIDTH-1:0] clamped_period;

    // >= rather than == so a shorter period copied in during PAUSE cannot strand cnt past the end
    assign at_end         = (cnt >= active_period - PERIOD_WIDTH'(1));
    assign step_now       = (state != IDLE) && enable && !hold && at_end;
    assign clamped_period = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    assign active         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        cnt_nxt            = cnt;
        phase_nxt          = phase;
        step_nxt           = 1'b0;
        rev_tick_nxt       = 1'b0;
        active_period_nxt  = active_period;
        pending_period_nxt = pending_period;
        pending_nxt        = period_pending;

        case (state)
            IDLE: begin
                if (phase_load) begin
                    phase_nxt = (phase_init >= TOTAL_PHASE_STAGES) ? 3'd0 : phase_init;
                end
                if (enable) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN, PAUSE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (hold) begin
                    state_nxt = PAUSE;
                end else begin
                    state_nxt = RUN;
                    if (at_end) begin
                        cnt_nxt  = '0;
                        step_nxt = 1'b1;
                        if (!dir) begin
                            phase_nxt    = (phase == LAST_PHASE) ? 3'd0 : phase + 3'd1;
                            rev_tick_nxt = (phase == LAST_PHASE);
                        end else begin
                            phase_nxt    = (phase == 3'd0) ? LAST_PHASE : phase - 3'd1;
                            rev_tick_nxt = (phase == 3'd0);
                        end
                    end else begin
                        cnt_nxt = cnt + PERIOD_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // While running, the pending period only lands on a step edge so no step is shortened
        if (period_pending && ((state != RUN) || step_now)) begin
            active_period_nxt = pending_period;
            pending_nxt       = 1'b0;
        end
        if (period_we) begin
            pending_period_nxt = clamped_period;
            pending_nxt        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            phase          <= 3'd0;
            step           <= 1'b0;
            rev_tick       <= 1'b0;
            active_period  <= '1;
            pending_period <= '1;
            period_pending <= 1'b0;
        end else begin
            cnt            <= cnt_nxt;
            phase          <= phase_nxt;
            step           <= step_nxt;
            rev_tick       <= rev_tick_nxt;
            active_period  <= active_period_nxt;
            pending_period <= pending_period_nxt;
            period_pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_mbldcm_commutation_sequencer.sv
// Directed self-checking bench for the commutation sequencer: step spacing, direction,
// period double-buffering and clamping, pause, preload, stop and async reset.
module tb_mbldcm_commutation_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        hold;
    logic        dir;
    logic [15:0] period;
    logic        period_we;
    logic [2:0]  phase_init;
    logic        phase_load;
    logic [2:0]  phase;
    logic        step;
    logic        rev_tick;
    logic        active;
    logic        period_pending;

    int total = 0;
    int bad   = 0;
    int gap;
    int step_seen;

    mbldcm_commutation_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .hold           (hold),
        .dir            (dir),
        .period         (period),
        .period_we      (period_we),
        .phase_init     (phase_init),
        .phase_load     (phase_load),
        .phase          (phase),
        .step           (step),
        .rev_tick       (rev_tick),
        .active         (active),
        .period_pending (period_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driving and sampling happens 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One-cycle period write strobe
    task automatic applyStimulus(input logic [15:0] p);
        period    = p;
        period_we = 1'b1;
        tick(1);
        period_we = 1'b0;
    endtask

    // Cycles until the next step pulse, capped at budget so a missing step fails the count check
    task automatic waitStep(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick(1);
            cycles++;
        end while (step !== 1'b1 && cycles < budget);
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        hold       = 1'b0;
        dir        = 1'b0;
        period     = 16'd0;
        period_we  = 1'b0;
        phase_init = 3'd0;
        phase_load = 1'b0;
        tick(3);
        checkOutput("reset_phase", 16'(phase), 16'd0);
        checkOutput("reset_step", 16'(step), 16'd0);
        checkOutput("reset_rev", 16'(rev_tick), 16'd0);
        checkOutput("reset_active", 16'(active), 16'd0);
        checkOutput("reset_pending", 16'(period_pending), 16'd0);
        rst = 1'b0;
        tick(1);

        $display("[TB] forward run, period 4");
        applyStimulus(16'd4);
        checkOutput("pend_set_idle", 16'(period_pending), 16'd1);
        tick(1);
        checkOutput("pend_clr_idle", 16'(period_pending), 16'd0);
        enable = 1'b1;
        waitStep(40, gap);
        checkOutput("fwd_first_gap", 16'(gap), 16'd5);
        checkOutput("fwd_phase1", 16'(phase), 16'd1);
        checkOutput("fwd_rev1", 16'(rev_tick), 16'd0);
        checkOutput("fwd_active", 16'(active), 16'd1);
        for (int i = 2; i <= 6; i++) begin
            waitStep(40, gap);
            checkOutput("fwd_gap", 16'(gap), 16'd4);
            checkOutput("fwd_phase", 16'(phase), 16'(i % 6));
            checkOutput("fwd_rev", 16'(rev_tick), (i == 6) ? 16'd1 : 16'd0);
        end
        enable = 1'b0;
        tick(1);
        checkOutput("stop_active", 16'(active), 16'd0);

        $display("[TB] reverse run, period 3");
        applyStimulus(16'd3);
        tick(1);
        dir    = 1'b1;
        enable = 1'b1;
        waitStep(40, gap);
        checkOutput("rev_first_gap", 16'(gap), 16'd4);
        checkOutput("rev_phase5", 16'(phase), 16'd5);
        checkOutput("rev_wrap_tick", 16'(rev_tick), 16'd1);
        waitStep(40, gap);
        checkOutput("rev_gap4", 16'(gap), 16'd3);
        checkOutput("rev_phase4", 16'(phase), 16'd4);
        checkOutput("rev_no_tick", 16'(rev_tick), 16'd0);
        waitStep(40, gap);
        checkOutput("rev_gap3", 16'(gap), 16'd3);
        checkOutput("rev_phase3", 16'(phase), 16'd3);
        enable = 1'b0;
        dir    = 1'b0;
        tick(1);

        $display("[TB] period change while running");
        applyStimulus(16'd10);
        tick(1);
        enable = 1'b1;
        waitStep(40, gap);
        checkOutput("p10_first_gap", 16'(gap), 16'd11);
        checkOutput("p10_phase", 16'(phase), 16'd4);
        tick(3);
        applyStimulus(16'd20);
        checkOutput("p20_pending", 16'(period_pending), 16'd1);
        waitStep(40, gap);
        checkOutput("p20_old_gap_rest", 16'(gap), 16'd6);
        checkOutput("p20_applied", 16'(period_pending), 16'd0);
        checkOutput("p20_phase5", 16'(phase), 16'd5);
        waitStep(40, gap);
        checkOutput("p20_new_gap", 16'(gap), 16'd20);
        checkOutput("p20_phase0", 16'(phase), 16'd0);
        checkOutput("p20_rev", 16'(rev_tick), 16'd1);
        enable = 1'b0;
        tick(1);

        $display("[TB] period clamp");
        applyStimulus(16'd0);
        applyStimulus(16'd1);
        tick(1);
        enable = 1'b1;
        waitStep(40, gap);
        checkOutput("clamp_first_gap", 16'(gap), 16'd3);
        checkOutput("clamp_phase1", 16'(phase), 16'd1);
        for (int i = 2; i <= 8; i++) begin
            waitStep(40, gap);
            checkOutput("clamp_gap", 16'(gap), 16'd2);
            checkOutput("clamp_phase", 16'(phase), 16'(i % 6));
        end
        enable = 1'b0;
        tick(1);

        $display("[TB] pause");
        applyStimulus(16'd5);
        tick(1);
        enable = 1'b1;
        waitStep(40, gap);
        checkOutput("hold_first_gap", 16'(gap), 16'd6);
        checkOutput("hold_phase3", 16'(phase), 16'd3);
        tick(2);
        hold = 1'b1;
        step_seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (step === 1'b1) step_seen++;
        end
        hold = 1'b0;
        checkOutput("hold_no_step", 16'(step_seen), 16'd0);
        checkOutput("hold_phase_frozen", 16'(phase), 16'd3);
        checkOutput("hold_active", 16'(active), 16'd1);
        waitStep(40, gap);
        checkOutput("hold_rest_gap", 16'(gap), 16'd3);
        checkOutput("hold_phase4", 16'(phase), 16'd4);
        enable = 1'b0;
        tick(1);

        $display("[TB] preload, stop, async reset");
        phase_init = 3'd7;
        phase_load = 1'b1;
        tick(1);
        checkOutput("load_clamp", 16'(phase), 16'd0);
        phase_init = 3'd4;
        tick(1);
        phase_load = 1'b0;
        checkOutput("load_4", 16'(phase), 16'd4);
        checkOutput("load_no_step", 16'(step), 16'd0);
        enable = 1'b1;
        waitStep(40, gap);
        checkOutput("load_run_gap", 16'(gap), 16'd6);
        checkOutput("load_phase5", 16'(phase), 16'd5);
        tick(2);
        enable = 1'b0;
        tick(1);
        checkOutput("drop_active", 16'(active), 16'd0);
        step_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (step === 1'b1) step_seen++;
        end
        checkOutput("drop_no_step", 16'(step_seen), 16'd0);
        checkOutput("drop_phase_hold", 16'(phase), 16'd5);
        enable = 1'b1;
        tick(2);
        phase_init = 3'd1;
        phase_load = 1'b1;
        tick(1);
        phase_load = 1'b0;
        checkOutput("load_ignored_run", 16'(phase), 16'd5);
        applyStimulus(16'd7);
        checkOutput("run_pending", 16'(period_pending), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_phase", 16'(phase), 16'd0);
        checkOutput("arst_active", 16'(active), 16'd0);
        checkOutput("arst_step", 16'(step), 16'd0);
        checkOutput("arst_rev", 16'(rev_tick), 16'd0);
        checkOutput("arst_pending", 16'(period_pending), 16'd0);
        enable = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
